mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//  MEM/WB pipeline register and write-back sequencer of the 8-bit pipelined core.
//  Captures one retiring instruction per cycle, selects write-back data, and drives
//  the register-file write port and SP (R3) inc/dec strobes.
//  Register-file write port: WE, RW_addr, WD. SP strobes: IncSP, DecSP.
//  The register file samples these on the falling edge of clk.
//  Splits a conflicting SP update + R3 write into two ordered beats, stalling MEM meanwhile.
// PARAMETERS
//  DATA_W   8  data width of write-back path
//  ADDR_W   2  register address width
//  SP_ADDR  3  register index of the stack pointer
// PORTS
//  clk          in   1       core clock, all state updates on posedge
//  rst          in   1       synchronous, active-high reset
//  in_valid     in   1       MEM stage presents a retiring instruction
//  in_ready     out  1       stage can accept this cycle (combinational from state)
//  flush        in   1       discard the instruction offered this cycle
//  in_we        in   1       instruction writes a register
//  in_rd        in   ADDR_W  destination register
//  in_wb_sel    in   2       0=ALU result, 1=memory data, 2=input port, 3=in_imm
//  in_alu       in   DATA_W  ALU result
//  in_mem       in   DATA_W  memory read data
//  in_port      in   DATA_W  input-port data
//  in_imm       in   DATA_W  immediate / return-address value
//  in_inc_sp    in   1       instruction post-increments SP (POP/RET/RTI)
//  in_dec_sp    in   1       instruction decrements SP (PUSH/CALL/INTR)
//  WE           out  1       register-file write enable (registered)
//  RW_addr      out  ADDR_W  register-file write address (registered)
//  WD           out  DATA_W  register-file write data (registered)
//  IncSP        out  1       SP increment strobe (registered)
//  DecSP        out  1       SP decrement strobe (registered)
//  sp_err       out  1       sticky: in_inc_sp and in_dec_sp were seen together
// BEHAVIOUR
//  - Reset: WE, RW_addr, WD, IncSP, DecSP = 0, sp_err = 0, state = RUN, pending beat cleared.
//  - rst has priority over flush and in_valid.
//  - Accept: accept = in_valid & in_ready & ~flush.
//  - Latency: outputs reflect an accepted instruction on the cycle after acceptance.
//  - Outputs are one-cycle pulses; with no accept and no pending beat, WE, IncSP and DecSP are 0.
//  - WD mux: selected by in_wb_sel, captured at accept time. RW_addr = in_rd.
//  - WE = in_we. WD and RW_addr hold their last value when WE = 0.
//  - in_inc_sp & in_dec_sp both set: drop both strobes, set sp_err (sticky until rst),
//    still perform any register write.
//  - FSM RUN (in_ready = 1):
//    - accept with no conflict -> emit all fields in one beat, stay in RUN.
//    - Conflict = in_we & in_rd==SP_ADDR & exactly one of inc/dec.
//    - accept with conflict -> beat 1 emits only IncSP/DecSP (WE = 0) and stores the write; go SPLIT.
//  - FSM SPLIT (in_ready = 0):
//    - emit the stored write (WE = 1, RW_addr = SP_ADDR, WD = stored), strobes 0; return to RUN.
//    - Final R3 = written data, never the lost SP+/-1.
//  - flush: ignores the offered instruction only. It does not cancel a SPLIT beat
//    already committed. MEM must keep in_valid/fields stable while in_ready = 0.
//  - SP wrap-around is handled by the register file; this stage never computes SP values.
//  - rst during SPLIT: pending write discarded, outputs 0 next cycle.
// STRUCTURE
//  - Shared package cpu_pkg: WB_SEL_ALU/MEM/PORT/IMM encodings, SP_ADDR, DATA_W, ADDR_W.
//  - Shared package cpu_pkg: FSM state encoding wb_state_t {RUN, SPLIT}.
//  - One sub-module is natural: wb_mux (4:1 write-back data select, combinational).
//  - FSM, pipeline register and sticky error live in mem_wb_stage.
// TESTING
//  1. rst=1 two cycles -> all outputs 0, in_ready=1; release with in_valid=0 -> outputs stay 0.
//  2. ALU write: accept we=1,rd=1,sel=0,alu=0x5A
//     -> next cycle WE=1,RW_addr=1,WD=0x5A; following cycle WE=0.
//  3. PUSH: accept dec_sp=1,we=0 -> next cycle DecSP=1,WE=0; no stall.
//     Back-to-back POP R0 (inc=1,we=1,rd=0,sel=1,mem=0x33) -> IncSP=1,WE=1,WD=0x33 in one beat.
//  4. POP R3 conflict: inc=1,we=1,rd=3,mem=0x7F.
//     -> beat1 IncSP=1,WE=0, in_ready=0; beat2 WE=1,RW_addr=3,WD=0x7F,IncSP=0.
//     -> in_ready=1 after; held next instruction retires in beat 3.
//  5. flush=1 with valid ALU write -> no output pulse.
//     flush=1 during SPLIT beat -> pending R3 write still issued.
//  6. inc=1 & dec=1 with we=1,rd=2,alu=0x11 -> WE=1,WD=0x11, both strobes 0, sp_err=1 until rst.
//     Assert rst mid-SPLIT -> stored write never appears.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit pipelined core: datapath widths, the stack
// pointer index, write-back select encodings and the write-back FSM states.
package cpu_pkg;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 2;
    localparam int SP_ADDR = 3;

    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_MEM  = 2'd1;
    localparam logic [1:0] WB_SEL_PORT = 2'd2;
    localparam logic [1:0] WB_SEL_IMM  = 2'd3;

    typedef logic [0:0] wb_state_t;
    localparam wb_state_t RUN   = 1'b0;
    localparam wb_state_t SPLIT = 1'b1;

endpackage

// File: rtl/wb_mux.sv
// 4:1 write-back data select feeding the MEM/WB pipeline register.
module wb_mux
    import cpu_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic [1:0]   sel,
    input  logic [W-1:0] alu,
    input  logic [W-1:0] mem,
    input  logic [W-1:0] port,
    input  logic [W-1:0] imm,
    output logic [W-1:0] wd
);

    always_comb begin
        unique case (sel)
            WB_SEL_ALU:  wd = alu;
            WB_SEL_MEM:  wd = mem;
            WB_SEL_PORT: wd = port;
            default:     wd = imm;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and write-back sequencer: drives the register-file
// write port and SP strobes, splitting an SP update plus an R3 write into two beats.
module mem_wb_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W  = cpu_pkg::DATA_W,
    parameter int ADDR_W  = cpu_pkg::ADDR_W,
    parameter int SP_ADDR = cpu_pkg::SP_ADDR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic              in_we,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [1:0]        in_wb_sel,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_mem,
    input  logic [DATA_W-1:0] in_port,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              in_inc_sp,
    input  logic              in_dec_sp,
    output logic              WE,
    output logic [ADDR_W-1:0] RW_addr,
    output logic [DATA_W-1:0] WD,
    output logic              IncSP,
    output logic              DecSP,
    output logic              sp_err
);

    localparam logic [ADDR_W-1:0] SP_IDX = ADDR_W'(SP_ADDR);

    wb_state_t         state;
    logic [DATA_W-1:0] pend_wd;
    logic [DATA_W-1:0] wb_data;
    logic              accept;
    logic              sp_both;
    logic              conflict;

    wb_mux #(.W(DATA_W)) u_wb_mux (
        .sel  (in_wb_sel),
        .alu  (in_alu),
        .mem  (in_mem),
        .port (in_port),
        .imm  (in_imm),
        .wd   (wb_data)
    );

    assign in_ready = (state == RUN);
    assign accept   = in_valid & in_ready & ~flush;
    assign sp_both  = in_inc_sp & in_dec_sp;
    // Only a single SP update can collide with an R3 write; a dropped pair cannot.
    assign conflict = in_we & (in_rd == SP_IDX) & (in_inc_sp ^ in_dec_sp);

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values; the defaults make WE and the strobes one-cycle pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            WE      <= 1'b0;
            RW_addr <= '0;
            WD      <= '0;
            IncSP   <= 1'b0;
            DecSP   <= 1'b0;
            sp_err  <= 1'b0;
            // NOTE: the pending write is a single register, not an array, so it is
            // cleared here to guarantee a reset mid-SPLIT can never leak it.
            pend_wd <= '0;
        end else begin
            WE    <= 1'b0;
            IncSP <= 1'b0;
            DecSP <= 1'b0;

            if (state == SPLIT) begin
                WE      <= 1'b1;
                RW_addr <= SP_IDX;
                WD      <= pend_wd;
                state   <= RUN;
            end else if (accept) begin
                if (sp_both)
                    sp_err <= 1'b1;

                if (conflict) begin
                    // Beat 1: SP moves first so the stored R3 value wins afterwards.
                    IncSP   <= in_inc_sp;
                    DecSP   <= in_dec_sp;
                    pend_wd <= wb_data;
                    state   <= SPLIT;
                end else begin
                    WE    <= in_we;
                    IncSP <= in_inc_sp & ~sp_both;
                    DecSP <= in_dec_sp & ~sp_both;
                    if (in_we) begin
                        RW_addr <= in_rd;
                        WD      <= wb_data;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage with hand-computed expectations.
module tb_mem_wb_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       flush;
    logic       in_we;
    logic [1:0] in_rd;
    logic [1:0] in_wb_sel;
    logic [7:0] in_alu;
    logic [7:0] in_mem;
    logic [7:0] in_port;
    logic [7:0] in_imm;
    logic       in_inc_sp;
    logic       in_dec_sp;
    logic       WE;
    logic [1:0] RW_addr;
    logic [7:0] WD;
    logic       IncSP;
    logic       DecSP;
    logic       sp_err;

    int n_checks = 0;
    int n_fail   = 0;

    mem_wb_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .in_we     (in_we),
        .in_rd     (in_rd),
        .in_wb_sel (in_wb_sel),
        .in_alu    (in_alu),
        .in_mem    (in_mem),
        .in_port   (in_port),
        .in_imm    (in_imm),
        .in_inc_sp (in_inc_sp),
        .in_dec_sp (in_dec_sp),
        .WE        (WE),
        .RW_addr   (RW_addr),
        .WD        (WD),
        .IncSP     (IncSP),
        .DecSP     (DecSP),
        .sp_err    (sp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic we, input logic [1:0] rd,
                         input logic [1:0] sel, input logic inc, input logic dec);
        in_valid  = v;
        in_we     = we;
        in_rd     = rd;
        in_wb_sel = sel;
        in_inc_sp = inc;
        in_dec_sp = dec;
    endtask

    task automatic check_out(input string tag, input logic we, input logic [1:0] ra,
                             input logic [7:0] wd, input logic inc, input logic dec);
        check({tag, ".WE"},      WE,      we);
        check({tag, ".RW_addr"}, RW_addr, ra);
        check({tag, ".WD"},      WD,      wd);
        check({tag, ".IncSP"},   IncSP,   inc);
        check({tag, ".DecSP"},   DecSP,   dec);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        in_alu = 8'h00; in_mem = 8'h00; in_port = 8'h00; in_imm = 8'h00;
        offer(0, 0, 0, 0, 0, 0);

        // 1. reset
        step(); step();
        check_out("rst", 0, 0, 8'h00, 0, 0);
        check("rst.sp_err", sp_err, 0);
        check("rst.in_ready", in_ready, 1);
        rst = 1'b0;
        step();
        check_out("idle", 0, 0, 8'h00, 0, 0);

        // 2. ALU write, other sources differ so the mux choice is visible
        in_alu = 8'h5A; in_mem = 8'h99; in_port = 8'hC3; in_imm = 8'h12;
        offer(1, 1, 2'd1, 2'd0, 0, 0);
        step();
        check_out("alu", 1, 2'd1, 8'h5A, 0, 0);
        offer(0, 0, 0, 0, 0, 0);
        step();
        check_out("alu_after", 0, 2'd1, 8'h5A, 0, 0);

        // 3. PUSH then back-to-back POP R0
        offer(1, 0, 2'd0, 2'd0, 0, 1);
        check("push.in_ready", in_ready, 1);
        step();
        check_out("push", 0, 2'd1, 8'h5A, 0, 1);
        check("push.no_stall", in_ready, 1);
        in_mem = 8'h33;
        offer(1, 1, 2'd0, 2'd1, 1, 0);
        step();
        check_out("pop_r0", 1, 2'd0, 8'h33, 1, 0);

        // 4. POP R3 conflict split, then a held ALU write
        in_mem = 8'h7F;
        offer(1, 1, 2'd3, 2'd1, 1, 0);
        step();
        check_out("pop_r3.b1", 0, 2'd0, 8'h33, 1, 0);
        check("pop_r3.b1.in_ready", in_ready, 0);
        in_alu = 8'h44;
        offer(1, 1, 2'd2, 2'd0, 0, 0);
        step();
        check_out("pop_r3.b2", 1, 2'd3, 8'h7F, 0, 0);
        check("pop_r3.b2.in_ready", in_ready, 1);
        step();
        check_out("held.b3", 1, 2'd2, 8'h44, 0, 0);

        // input-port select
        in_port = 8'h5C;
        offer(1, 1, 2'd1, 2'd2, 0, 0);
        step();
        check_out("port", 1, 2'd1, 8'h5C, 0, 0);

        // 5. flush drops the offered instruction
        in_alu = 8'hEE;
        offer(1, 1, 2'd0, 2'd0, 0, 0);
        flush = 1'b1;
        step();
        check_out("flush", 0, 2'd1, 8'h5C, 0, 0);
        flush = 1'b0;

        // flush during the SPLIT beat keeps the committed R3 write
        in_imm = 8'hA5;
        offer(1, 1, 2'd3, 2'd3, 0, 1);
        step();
        check_out("call_r3.b1", 0, 2'd1, 8'h5C, 0, 1);
        flush = 1'b1;
        step();
        check_out("call_r3.b2_flush", 1, 2'd3, 8'hA5, 0, 0);
        flush = 1'b0;
        offer(0, 0, 0, 0, 0, 0);
        step();
        check("quiet.WE", WE, 0);
        check("quiet.sp_err", sp_err, 0);

        // 6. inc+dec together: write kept, strobes dropped, sticky error
        in_alu = 8'h11;
        offer(1, 1, 2'd2, 2'd0, 1, 1);
        step();
        check_out("both", 1, 2'd2, 8'h11, 0, 0);
        check("both.sp_err", sp_err, 1);
        offer(0, 0, 0, 0, 0, 0);
        step();
        check("sticky.sp_err", sp_err, 1);

        // reset in the middle of a split discards the stored write
        in_mem = 8'h66;
        offer(1, 1, 2'd3, 2'd1, 1, 0);
        step();
        check("rsplit.b1.IncSP", IncSP, 1);
        check("rsplit.b1.in_ready", in_ready, 0);
        rst = 1'b1;
        offer(0, 0, 0, 0, 0, 0);
        step();
        check_out("rsplit.rst", 0, 2'd0, 8'h00, 0, 0);
        check("rsplit.sp_err", sp_err, 0);
        check("rsplit.in_ready", in_ready, 1);
        rst = 1'b0;
        step();
        check_out("rsplit.after", 0, 2'd0, 8'h00, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
